// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the dmem_lsu load/store unit: RV32I funct3 codes,
// FSM state type and the request legality check.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_t;

  // Returns 1 for misaligned, out-of-range or illegal-funct3 requests.
  function automatic logic lsu_err(input logic       we,
                                   input logic [2:0] funct3,
                                   input logic [1:0] addr_lo,
                                   input logic       out_of_range);
    logic err;
    err = out_of_range;
    case (funct3)
      F3_B:    err = err;
      F3_H:    err = err | addr_lo[0];
      F3_W:    err = err | (|addr_lo);
      // Unsigned variants exist only as loads.
      F3_BU:   err = err | we;
      F3_HU:   err = err | we | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the execute stage (master) and dmem_lsu (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : response payload
interface dmem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational byte-lane steering for dmem_lsu.
//   funct3_i  : RV32I funct3 of the request
//   addr_lo_i : byte offset within the word
//   wdata_i   : right-aligned store data
//   rword_i   : raw RAM word read at the request address
//   be_o      : store byte enables
//   wlane_o   : store data replicated onto its lanes
//   rdata_o   : selected load lane(s), sign/zero extended
module dmem_lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rword_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wlane_o,
  output logic [XLEN-1:0]   rdata_o
);
  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] rshift;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;

  // Replicating the data onto every lane lets the byte enables alone pick the target.
  always_comb begin
    be_o    = '0;
    wlane_o = '0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = NB'(1) << addr_lo_i;
        wlane_o = {NB{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = NB'(3) << {addr_lo_i[1], 1'b0};
        wlane_o = {(NB/2){wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = '1;
        wlane_o = wdata_i;
      end
      default: begin
        be_o    = '0;
        wlane_o = '0;
      end
    endcase
  end

  // Halfword offsets are even once legal, so a byte-granular shift serves both widths.
  assign rshift = rword_i >> {addr_lo_i, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = rshift[15:0];

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{(XLEN-8){rbyte[7]}}, rbyte};
      F3_H:    rdata_o = {{(XLEN-16){rhalf[15]}}, rhalf};
      F3_W:    rdata_o = rword_i;
      F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, rbyte};
      F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, rhalf};
      default: rdata_o = '0;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit with integrated data RAM and configurable wait states.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : dmem_lsu_if slave (request in, response out)
// One request in flight: IDLE -> ACCESS (WAIT_STATES extra cycles) -> RESP -> IDLE.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic       clk_i,
  input logic       rst_ni,
  dmem_lsu_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned NB     = XLEN / 8;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic              req_err;
  logic              mem_we;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wlane;
  logic [XLEN-1:0]   rword;
  logic [XLEN-1:0]   load_data;

  assign idx     = addr_q[ADDR_W+1:2];
  // Any address bit above the RAM index means word index >= DEPTH_WORDS.
  assign oor     = |addr_q[XLEN-1:ADDR_W+2];
  assign req_err = lsu_err(we_q, f3_q, addr_q[1:0], oor);
  assign rword   = mem[idx];

  dmem_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3_i (f3_q),
    .addr_lo_i(addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  (rword),
    .be_o     (be),
    .wlane_o  (wlane),
    .rdata_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = we_q & ~req_err;
          err_d   = req_err;
          rdata_d = (we_q || req_err) ? '0 : load_data;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is deliberately unreset; a reset holds state_q in StIdle so no write can commit.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_er;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst3_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus, steered to one DUT by sel (0: WAIT=0, 1: WAIT=3).
  logic        sel = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_we = 1'b0;
  logic [2:0]  t_f3 = 3'b000;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_wdata = 32'h0;
  logic        t_rready = 1'b0;

  dmem_lsu_if #(.XLEN(32)) bus0 ();
  dmem_lsu_if #(.XLEN(32)) bus3 ();

  dmem_lsu #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk_i (clk),
    .rst_ni(rst0_n),
    .bus   (bus0)
  );

  dmem_lsu #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst3_n),
    .bus   (bus3)
  );

  assign bus0.req_valid  = t_valid & ~sel;
  assign bus0.req_we     = t_we;
  assign bus0.req_funct3 = t_f3;
  assign bus0.req_addr   = t_addr;
  assign bus0.req_wdata  = t_wdata;
  assign bus0.rsp_ready  = t_rready & ~sel;
  assign bus3.req_valid  = t_valid & sel;
  assign bus3.req_we     = t_we;
  assign bus3.req_funct3 = t_f3;
  assign bus3.req_addr   = t_addr;
  assign bus3.req_wdata  = t_wdata;
  assign bus3.rsp_ready  = t_rready & sel;

  wire        obs_ready = sel ? bus3.req_ready : bus0.req_ready;
  wire        obs_valid = sel ? bus3.rsp_valid : bus0.rsp_valid;
  wire [31:0] obs_rdata = sel ? bus3.rsp_rdata : bus0.rsp_rdata;
  wire        obs_err   = sel ? bus3.rsp_err   : bus0.rsp_err;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] m0 [256];   // expected contents of DUT0 RAM
  int          acc_cyc;

  function automatic req_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    req_t r;
    r.we = we; r.f3 = f3; r.addr = a; r.wdata = wd; r.exp_rd = rd; r.exp_er = er;
    return r;
  endfunction

  // Handshakes one request; returns at #1 into the first cycle after acceptance.
  task automatic issue(input req_t r, input bit push);
    int n = 0;
    exp_t e;
    logic [31:0] w;
    t_we = r.we; t_f3 = r.f3; t_addr = r.addr; t_wdata = r.wdata; t_valid = 1'b1;
    while (obs_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required=1", r.addr, obs_ready);
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    acc_cyc = cyc;
    if (push) begin
      e.rd = r.exp_rd; e.er = r.exp_er;
      sb.push_back(e);
    end
    if (!sel && push && r.we && !r.exp_er) begin
      w = m0[r.addr[9:2]];
      if (r.f3 == F3_B) w[8*r.addr[1:0] +: 8] = r.wdata[7:0];
      else if (r.f3 == F3_H) w[16*r.addr[1] +: 16] = r.wdata[15:0];
      else w = r.wdata;
      m0[r.addr[9:2]] = w;
    end
  endtask

  task automatic xfer(input req_t r, output logic [31:0] rd, output logic er,
                      output int lat, output bit tmo);
    int n = 0;
    issue(r, 1'b1);
    while (obs_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    tmo = (obs_valid !== 1'b1);
    rd  = obs_rdata;
    er  = obs_err;
    lat = cyc - acc_cyc;
    t_rready = 1'b1;
    @(posedge clk); #1;
    t_rready = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready dut=%0d got=%b required=1", s, obs_ready); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid dut=%0d got=%b required=0", s, obs_valid); end
      checks++;
      if (obs_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata dut=%0d got=%h required=0", s, obs_rdata); end
      checks++;
      if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_err dut=%0d got=%b required=0", s, obs_err); end
    end
  endtask

  // Runs a list on the selected DUT, comparing each response with the scoreboard.
  task automatic test_list(input string name, input req_t q[$]);
    logic [31:0] rd; logic er; int lat; bit tmo; exp_t e;
    int explat = sel ? 4 : 1;
    foreach (q[i]) begin
      xfer(q[i], rd, er, lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rd || er !== e.er) begin
        errors++;
        $display("FAIL %s[%0d] addr=%h got rdata=%h err=%b timeout=%0d required rdata=%h err=%b",
                 name, i, q[i].addr, rd, er, tmo, e.rd, e.er);
      end
      checks++;
      if (lat != explat) begin
        errors++;
        $display("FAIL %s_latency[%0d] got=%0d required=%0d", name, i, lat, explat);
      end
    end
  endtask

  task automatic test_fill();
    req_t q[$];
    logic [31:0] pat;
    sel = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      pat = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
      q.push_back(mk(1'b1, F3_W, 32'(i * 4), pat, 32'h0, 1'b0));
    end
    test_list("fill", q);
    q.delete();
    sel = 1'b1; @(posedge clk); #1;
    q.push_back(mk(1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0));
    q.push_back(mk(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0));
    test_list("fill3", q);
  endtask

  task automatic test_word();
    req_t q[$];
    sel = 1'b0; @(posedge clk); #1;
    q.push_back(mk(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
    q.push_back(mk(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
    test_list("word", q);
  endtask

  task automatic test_byte_half();
    req_t q[$];
    sel = 1'b0; @(posedge clk); #1;
    q.push_back(mk(1'b1, F3_W,  32'h10, 32'h00000000, 32'h0, 1'b0));
    q.push_back(mk(1'b1, F3_B,  32'h13, 32'hABCDEF80, 32'h0, 1'b0));
    q.push_back(mk(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0));
    q.push_back(mk(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0));
    q.push_back(mk(1'b0, F3_W,  32'h10, 32'h0, 32'h80000000, 1'b0));
    q.push_back(mk(1'b0, F3_B,  32'h11, 32'h0, 32'h00000000, 1'b0));
    q.push_back(mk(1'b1, F3_W,  32'h14, 32'h00000000, 32'h0, 1'b0));
    q.push_back(mk(1'b1, F3_H,  32'h16, 32'h1234C001, 32'h0, 1'b0));
    q.push_back(mk(1'b0, F3_H,  32'h16, 32'h0, 32'hFFFFC001, 1'b0));
    q.push_back(mk(1'b0, F3_HU, 32'h16, 32'h0, 32'h0000C001, 1'b0));
    q.push_back(mk(1'b0, F3_W,  32'h14, 32'h0, 32'hC0010000, 1'b0));
    q.push_back(mk(1'b1, F3_H,  32'h14, 32'hAAAA7FFF, 32'h0, 1'b0));
    q.push_back(mk(1'b0, F3_H,  32'h14, 32'h0, 32'h00007FFF, 1'b0));
    q.push_back(mk(1'b0, F3_W,  32'h14, 32'h0, 32'hC0017FFF, 1'b0));
    test_list("byte_half", q);
  endtask

  task automatic test_misalign();
    req_t q[$];
    sel = 1'b0; @(posedge clk); #1;
    q.push_back(mk(1'b0, F3_H,  32'h11, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, F3_HU, 32'h13, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, F3_W,  32'h12, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b1, F3_W,  32'h12, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b1, F3_H,  32'h11, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b0, F3_W,  32'h10, 32'h0, 32'h80000000, 1'b0));
    test_list("misalign", q);
  endtask

  task automatic test_wait();
    exp_t e;
    req_t q[$];
    sel = 1'b1; @(posedge clk); #1;
    issue(mk(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0), 1'b1);
    // A store held on the request side while busy must be ignored.
    t_we = 1'b1; t_f3 = F3_W; t_wdata = 32'h55555555; t_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (obs_ready !== 1'b0) begin errors++; $display("FAIL wait_ready T+%0d got=%b required=0", k, obs_ready); end
      checks++;
      if (obs_valid !== (k == 5)) begin errors++; $display("FAIL wait_valid T+%0d got=%b required=%b", k, obs_valid, k == 5); end
      if (k < 5) begin @(posedge clk); #1; end
    end
    e = sb.pop_front();
    for (int h = 0; h < 4; h++) begin
      checks++;
      if (obs_valid !== 1'b1 || obs_rdata !== e.rd || obs_err !== e.er) begin
        errors++;
        $display("FAIL wait_hold[%0d] got valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                 h, obs_valid, obs_rdata, obs_err, e.rd, e.er);
      end
      if (h < 3) begin @(posedge clk); #1; end
    end
    t_valid = 1'b0; t_rready = 1'b1;
    @(posedge clk); #1;
    t_rready = 1'b0;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_release got valid=%b ready=%b required valid=0 ready=1", obs_valid, obs_ready);
    end
    q.push_back(mk(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0));
    test_list("wait_reread", q);
  endtask

  task automatic test_errors();
    req_t q[$];
    sel = 1'b0; @(posedge clk); #1;
    q.push_back(mk(1'b1, F3_W,  32'h400, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b1, F3_B,  32'h7FF, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b0, F3_W,  32'h400, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, F3_BU, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1));
    q.push_back(mk(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b1, F3_HU, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1));
    q.push_back(mk(1'b1, 3'b110, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1));
    test_list("errors", q);
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(mk(1'b0, F3_W, 32'(i * 4), 32'h0, m0[i], 1'b0));
    test_list("scan", q);
  endtask

  task automatic test_reset_access();
    req_t q[$];
    sel = 1'b1; @(posedge clk); #1;
    issue(mk(1'b1, F3_W, 32'h20, 32'h12345678, 32'h0, 1'b0), 1'b0);
    @(posedge clk); #1;
    rst3_n = 1'b0; #1;
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               obs_ready, obs_valid, obs_rdata, obs_err);
    end
    repeat (2) @(posedge clk);
    #1 rst3_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_lost got valid=%b ready=%b required valid=0 ready=1", obs_valid, obs_ready);
    end
    q.push_back(mk(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0));
    test_list("midreset_reread", q);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_word();
    test_byte_half();
    test_misalign();
    test_wait();
    test_errors();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
